// File: rtl/fifo_mac_seq_pkg.sv
// Shared types and width helpers for the FIFO/MAC sequencer.
package fifo_mac_seq_pkg;

  localparam int unsigned DefAddrW = 16;

  typedef logic [DefAddrW-1:0] addr_t;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFillReq = 3'd1,
    StFillWr  = 3'd2,
    StExec    = 3'd3,
    StFlush   = 3'd4,
    StDone    = 3'd5
  } state_t;

  // Row index width; a single FIFO still needs one bit.
  function automatic int unsigned row_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Column / exec count width, one spare bit so DEPTH itself is representable.
  function automatic int unsigned col_width(input int unsigned d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/seq_addr_gen.sv
// Row/column fill counters and the row-major memory address they select.
module seq_addr_gen
  import fifo_mac_seq_pkg::*;
#(
  parameter int unsigned       NUM_FIFOS = 8,
  parameter int unsigned       DEPTH     = 8,
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  localparam int unsigned      RowW      = row_width(NUM_FIFOS),
  localparam int unsigned      ColW      = col_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  output logic [RowW-1:0]   row,
  output logic [ColW-1:0]   col,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic            col_last;

  assign col_last = (col_q == ColW'(DEPTH - 1));
  assign last     = col_last && (row_q == RowW'(NUM_FIFOS - 1));

  // Advance column, wrap into the next row, return to origin after the last element.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (adv) begin
      if (col_last) begin
        col_d = '0;
        row_d = last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  // Arithmetic is done at ADDR_W so the address wraps modulo 2^ADDR_W.
  assign addr = BASE_ADDR + ADDR_W'(row_q) * ADDR_W'(DEPTH) + ADDR_W'(col_q);

endmodule

// File: rtl/fifo_mac_seq.sv
// FIFO/MAC sequencer: fills NUM_FIFOS row FIFOs from a read-handshake memory port, then pops
// them in lockstep for DEPTH cycles with the MACs enabled and pulses done.
// Optional build macro STATUS_CHK_EN adds a sticky FIFO flag-consistency error (err).
module fifo_mac_seq
  import fifo_mac_seq_pkg::*;
#(
  parameter int unsigned       NUM_FIFOS  = 8,
  parameter int unsigned       DEPTH      = 8,
  parameter int unsigned       DATA_WIDTH = 8,
  parameter int unsigned       ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  mem_rd,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_vld,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [NUM_FIFOS-1:0]  fifo_wren,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic [NUM_FIFOS-1:0]  fifo_rden,
  input  logic [NUM_FIFOS-1:0]  fifo_full,
  input  logic [NUM_FIFOS-1:0]  fifo_empty,
  output logic                  mac_clr,
  output logic                  mac_en,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned RowW = row_width(NUM_FIFOS);
  localparam int unsigned ColW = col_width(DEPTH);

  state_t                  state_q, state_d;
  logic [ColW-1:0]         exec_q, exec_d;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    mac_en_q;
  logic                    ag_clr, ag_adv;
  logic [RowW-1:0]         row;
  logic [ColW-1:0]         col;
  logic [ADDR_W-1:0]       addr;
  logic                    last;
  logic                    exec_last;
  logic                    unused_col;

  seq_addr_gen #(
    .NUM_FIFOS (NUM_FIFOS),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ag_clr),
    .adv   (ag_adv),
    .row   (row),
    .col   (col),
    .addr  (addr),
    .last  (last)
  );

  assign unused_col = ^col;
  assign exec_last  = (exec_q == ColW'(DEPTH - 1));

  // Sequencing: fill element by element, then a fixed-length exec burst.
  always_comb begin
    state_d = state_q;
    exec_d  = exec_q;
    ag_clr  = 1'b0;
    ag_adv  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFillReq;
          ag_clr  = 1'b1;
        end
      end
      StFillReq: begin
        if (mem_vld) state_d = StFillWr;
      end
      StFillWr: begin
        ag_adv = 1'b1;
        if (last) begin
          state_d = StExec;
          exec_d  = '0;
        end else begin
          state_d = StFillReq;
        end
      end
      StExec: begin
        if (exec_last) state_d = StFlush;
        else           exec_d  = exec_q + 1'b1;
      end
      StFlush: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, exec counter, captured read data and the one-cycle MAC enable delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      exec_q   <= '0;
      wdata_q  <= '0;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      exec_q   <= exec_d;
      // FIFO o_data is registered, so MAC enable trails the pop by one cycle.
      mac_en_q <= (state_q == StExec);
      if (state_q == StFillReq && mem_vld) wdata_q <= mem_data;
    end
  end

  assign mem_rd     = (state_q == StFillReq);
  // Address is forced to zero outside a request so the port is quiet at reset and in idle.
  assign mem_addr   = mem_rd ? addr : '0;
  assign fifo_wren  = (state_q == StFillWr) ? (NUM_FIFOS'(1) << row) : '0;
  assign fifo_wdata = wdata_q;
  assign fifo_rden  = {NUM_FIFOS{state_q == StExec}};
  assign mac_clr    = (state_q == StExec) && (exec_q == '0);
  assign mac_en     = mac_en_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);

`ifdef STATUS_CHK_EN
  logic err_q, err_set;

  // Flag checks; none of them feed back into sequencing.
  always_comb begin
    err_set = 1'b0;
    if (state_q == StFillWr && fifo_full[row])      err_set = 1'b1;
    if (mac_clr && (fifo_full != '1))               err_set = 1'b1;
    if (|(fifo_empty & fifo_rden))                  err_set = 1'b1;
    if (state_q == StDone && (fifo_empty != '1))    err_set = 1'b1;
  end

  // Sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | err_set;
  end

  assign err = err_q;
`else
  logic unused_flags;
  assign unused_flags = ^{fifo_full, fifo_empty};
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_mac_seq.sv
// Self-checking bench for fifo_mac_seq with a memory responder, FIFO bank model and
// a scoreboard derived from the element index (row-major, DEPTH per row).
module tb_fifo_mac_seq;

  localparam int NUM  = 8;
  localparam int DEP  = 8;
  localparam int ELEM = NUM * DEP;
`ifdef STATUS_CHK_EN
  localparam bit ChkOn = 1'b1;
`else
  localparam bit ChkOn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n, start;
  logic            mem_rd, mem_vld;
  logic [15:0]     mem_addr;
  logic [7:0]      mem_data;
  logic [NUM-1:0]  fifo_wren, fifo_rden, fifo_full, fifo_empty;
  logic [7:0]      fifo_wdata;
  logic            mac_clr, mac_en, busy, done, err;
  logic [45:0]     outs;

  logic            w_mem_rd;
  logic [15:0]     w_mem_addr;
  logic [NUM-1:0]  w_wren, w_rden;
  logic [7:0]      w_wdata;
  logic            w_clr, w_mac, w_busy, w_done, w_err;
  logic            unused_w;
  logic [15:0]     w_addrs [$];

  int              n_cmp = 0;
  int              n_bad = 0;
  int              waits [ELEM];
  int              wcnt, m_idx;
  logic [7:0]      salt;
  bit              force_row2;
  bit              exp_err;
  logic [7:0]      fdata [NUM][DEP];
  int              wp [NUM];
  int              rp [NUM];

  initial forever #5 clk = ~clk;

  fifo_mac_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_vld    (mem_vld),
    .mem_data   (mem_data),
    .fifo_wren  (fifo_wren),
    .fifo_wdata (fifo_wdata),
    .fifo_rden  (fifo_rden),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .mac_clr    (mac_clr),
    .mac_en     (mac_en),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Second instance only exercises address wrap-around with a zero-wait memory.
  fifo_mac_seq #(.BASE_ADDR(16'hFFF8)) dut_wrap (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_rd     (w_mem_rd),
    .mem_addr   (w_mem_addr),
    .mem_vld    (w_mem_rd),
    .mem_data   (w_mem_addr[7:0]),
    .fifo_wren  (w_wren),
    .fifo_wdata (w_wdata),
    .fifo_rden  (w_rden),
    .fifo_full  (8'h00),
    .fifo_empty (8'hFF),
    .mac_clr    (w_clr),
    .mac_en     (w_mac),
    .busy       (w_busy),
    .done       (w_done),
    .err        (w_err)
  );

  assign unused_w = ^{w_wren, w_rden, w_wdata, w_clr, w_mac, w_busy, w_done, w_err};
  assign outs = {mem_rd, mem_addr, fifo_wren, fifo_wdata, fifo_rden,
                 mac_clr, mac_en, busy, done, err};

  // Memory: data is the low address byte xor a per-pass salt; wait per request from waits[].
  assign mem_vld  = mem_rd && (wcnt == waits[m_idx % ELEM]);
  assign mem_data = mem_addr[7:0] ^ salt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt  <= 0;
      m_idx <= 0;
    end else if (mem_rd && mem_vld) begin
      wcnt  <= 0;
      m_idx <= m_idx + 1;
    end else if (mem_rd) begin
      wcnt <= wcnt + 1;
    end
  end

  // FIFO bank model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM; i++) begin
        wp[i] <= 0;
        rp[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NUM; i++) begin
        if (fifo_rden[i] && wp[i] != rp[i]) rp[i] <= rp[i] + 1;
        if (fifo_wren[i]) begin
          fdata[i][wp[i] % DEP] <= fifo_wdata;
          wp[i] <= wp[i] + 1;
        end
      end
    end
  end

  always_comb begin
    fifo_full  = '0;
    fifo_empty = '0;
    for (int i = 0; i < NUM; i++) begin
      fifo_full[i]  = (wp[i] - rp[i]) >= DEP;
      fifo_empty[i] = (wp[i] == rp[i]);
    end
    // Pretend FIFO 2 is full while its row is being written.
    if (force_row2 && (m_idx % ELEM) >= 2*DEP + 1 && (m_idx % ELEM) <= 3*DEP) fifo_full[2] = 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n)        w_addrs.delete();
    else if (w_mem_rd) w_addrs.push_back(w_mem_addr);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One fill+exec pass. wmode: 0 zero-wait/salt 0, 1 fixed wait, 2 random waits.
  task automatic run_pass(input int wmode, input int fixed_w, input bit rnd_start,
                          input bit force2, input int abort_at);
    int             w_total, e, n, n_rden, n_mac, t_rden, t_exp;
    logic [NUM-1:0] prev_rden;
    logic [7:0]     ex8;
    w_total = 0;
    for (int i = 0; i < ELEM; i++) begin
      waits[i] = (wmode == 2) ? int'($urandom_range(3, 0)) : fixed_w;
      w_total += waits[i];
    end
    salt       = (wmode == 0) ? 8'h00 : 8'($urandom_range(255, 0));
    force_row2 = force2;
    t_exp      = 2*ELEM + w_total + DEP + 2;
    e = 0; n = 0; n_rden = 0; n_mac = 0; t_rden = -1; prev_rden = '0;
    @(negedge clk);
    start = 1'b1;
    while (n < t_exp + 3) begin
      @(negedge clk);
      n++;
      if (abort_at >= 0 && e == abort_at && mem_rd) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check_eq("rst_async_outs", 64'(outs), 64'h0);
        @(negedge clk);
        check_eq("rst_outs", 64'(outs), 64'h0);
        check_eq("rst_busy", 64'(busy), 64'h0);
        rst_n      = 1'b1;
        force_row2 = 1'b0;
        return;
      end
      if (mem_rd) check_eq("mem_addr", 64'(mem_addr), 64'(e));
      if (fifo_wren != '0) begin
        ex8 = 8'(e) ^ salt;
        check_eq("wren_onehot", 64'(fifo_wren), 64'(8'(1) << (e / DEP)));
        check_eq("wdata", 64'(fifo_wdata), 64'(ex8));
        e++;
      end
      if (fifo_rden != '0) begin
        check_eq("rden_all", 64'(fifo_rden), 64'h0FF);
        if (n_rden == 0) t_rden = n;
        check_eq("mac_clr", 64'(mac_clr), 64'(n_rden == 0));
        for (int i = 0; i < NUM; i++) begin
          check_eq("fifo_nonempty", 64'(wp[i] != rp[i]), 64'h1);
          ex8 = 8'(i*DEP + n_rden) ^ salt;
          if (wp[i] != rp[i]) check_eq("pop_data", 64'(fdata[i][rp[i] % DEP]), 64'(ex8));
        end
        n_rden++;
      end else begin
        check_eq("mac_clr_no_rden", 64'(mac_clr), 64'h0);
      end
      check_eq("mac_en", 64'(mac_en), 64'(prev_rden != '0));
      if (mac_en) n_mac++;
      prev_rden = fifo_rden;
      check_eq("done", 64'(done), 64'(n == t_exp));
      check_eq("busy", 64'(busy), 64'(n <= t_exp));
      start = (rnd_start && n < t_exp) ? 1'($urandom_range(1, 0)) : 1'b0;
    end
    force_row2 = 1'b0;
    if (force2) exp_err = ChkOn;
    check_eq("wren_count", 64'(e), 64'(ELEM));
    check_eq("rden_cycles", 64'(n_rden), 64'(DEP));
    check_eq("exec_entry_cycle", 64'(t_rden), 64'(2*ELEM + 1 + w_total));
    check_eq("mac_en_cycles", 64'(n_mac), 64'(DEP));
    check_eq("fifos_empty", 64'(fifo_empty), 64'h0FF);
    check_eq("err", 64'(err), 64'(exp_err));
  endtask

  initial begin
    logic [15:0] exw;
    rst_n      = 1'b0;
    start      = 1'b0;
    force_row2 = 1'b0;
    salt       = 8'h00;
    exp_err    = 1'b0;
    for (int i = 0; i < ELEM; i++) waits[i] = 0;
    repeat (2) @(negedge clk);
    check_eq("reset_outs", 64'(outs), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of the fill at row 3, col 5.
    run_pass(0, 0, 1'b0, 1'b0, 3*DEP + 5);
    repeat (2) @(negedge clk);
    // Zero-wait fill; also replays from address 0 after the reset.
    run_pass(0, 0, 1'b0, 1'b0, -1);
    check_eq("wrap_count", 64'(w_addrs.size()), 64'(ELEM));
    for (int k = 0; k < ELEM && k < w_addrs.size(); k++) begin
      exw = 16'hFFF8 + 16'(k);
      check_eq("wrap_addr", 64'(w_addrs[k]), 64'(exw));
    end
    run_pass(1, 3, 1'b0, 1'b0, -1);
    run_pass(2, 0, 1'b1, 1'b0, -1);
    run_pass(2, 0, 1'b0, 1'b1, -1);
    run_pass(0, 0, 1'b1, 1'b0, -1);

    rst_n = 1'b0;
    #1;
    check_eq("final_reset_outs", 64'(outs), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
